// File: rtl/gx400_color_ram_out.sv
// gx400_color_ram_out: colour RAM and video output stage after the K005293 priority handler.
// A 2^PAL_AW x 16 palette is read each pixel (port A) and turned into registered RGB555;
// the 68000 reads and writes the same palette (port B) through a DTACK handshake.
// Optional feature macro: GX400_PAL_BLANK_EN forces RGB to 0 while the delayed blanks are low.
module gx400_color_ram_out #(
  parameter int PAL_AW   = 11,
  parameter int PIPE_DLY = 2
) (
  input  logic              i_CLK,
  input  logic              i_RST_n,
  input  logic              i_CEN6,
  input  logic [PAL_AW-1:0] i_COLOR_RAM_ADDR,
  input  logic              i_HBLANK_n,
  input  logic              i_VBLANK_n,
  input  logic              i_CPU_CS_n,
  input  logic              i_CPU_RW,
  input  logic              i_CPU_UDS_n,
  input  logic              i_CPU_LDS_n,
  input  logic [PAL_AW-1:0] i_CPU_ADDR,
  input  logic [15:0]       i_CPU_DIN,
  output logic [15:0]       o_CPU_DOUT,
  output logic              o_CPU_DTACK_n,
  output logic [4:0]        o_RED,
  output logic [4:0]        o_GREEN,
  output logic [4:0]        o_BLUE,
  output logic              o_HBLANK_n,
  output logic              o_VBLANK_n
);

  localparam int Depth = 1 << PAL_AW;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  logic [15:0]         mem [Depth];
  logic [14:0]         pix_rd_q;   // bit 15 of a palette word carries no colour
  logic [15:0]         cpu_rd_q;
  logic [PIPE_DLY-1:0] hb_pipe_q;
  logic [PIPE_DLY-1:0] vb_pipe_q;
  logic [14:0]         rgb_q;
  logic [15:0]         dout_q;
  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic                cyc_start;
  logic                cpu_we;
  logic                cpu_re;
  logic [1:0]          byte_en;
  logic                blank_force;

  assign cyc_start = ~i_CPU_CS_n & (~i_CPU_UDS_n | ~i_CPU_LDS_n);
  assign byte_en   = {~i_CPU_UDS_n, ~i_CPU_LDS_n};

  // Stage-1 blanks, aligned with the palette read register.
`ifdef GX400_PAL_BLANK_EN
  assign blank_force = ~(hb_pipe_q[PIPE_DLY-2] & vb_pipe_q[PIPE_DLY-2]);
`else
  assign blank_force = 1'b0;
`endif

  // CPU handshake next state; the RAM is touched only on the cycle-start clock.
  always_comb begin
    state_d = state_q;
    cpu_we  = 1'b0;
    cpu_re  = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_RST_n && cyc_start) begin
          if (i_CPU_RW) begin
            cpu_re  = 1'b1;
            state_d = StRd;
          end else begin
            cpu_we  = 1'b1;
            state_d = StAck;
          end
        end
      end
      StRd:    state_d = StAck;
      StAck:   if (i_CPU_CS_n) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // CPU state register.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Dual-port palette: pixel read on CEN6, CPU byte-enabled write / word read.
  // Nonblocking writes give the pixel port the old word on a same-clock collision.
  always_ff @(posedge i_CLK) begin
    if (i_CEN6) pix_rd_q <= mem[i_COLOR_RAM_ADDR][14:0];
    if (cpu_we) begin
      if (byte_en[1]) mem[i_CPU_ADDR][15:8] <= i_CPU_DIN[15:8];
      if (byte_en[0]) mem[i_CPU_ADDR][7:0]  <= i_CPU_DIN[7:0];
    end
    if (cpu_re) cpu_rd_q <= mem[i_CPU_ADDR];
  end

  // CPU read data holds between reads.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n)              dout_q <= 16'h0000;
    else if (state_q == StRd)  dout_q <= cpu_rd_q;
  end

  // Blank delay line and RGB output register, both advancing on CEN6.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      hb_pipe_q <= '0;
      vb_pipe_q <= '0;
      rgb_q     <= 15'h0000;
    end else if (i_CEN6) begin
      hb_pipe_q <= {hb_pipe_q[PIPE_DLY-2:0], i_HBLANK_n};
      vb_pipe_q <= {vb_pipe_q[PIPE_DLY-2:0], i_VBLANK_n};
      rgb_q     <= blank_force ? 15'h0000 : pix_rd_q;
    end
  end

  assign o_CPU_DOUT    = dout_q;
  assign o_CPU_DTACK_n = (state_q != StAck);
  assign o_RED         = rgb_q[4:0];
  assign o_GREEN       = rgb_q[9:5];
  assign o_BLUE        = rgb_q[14:10];
  assign o_HBLANK_n    = hb_pipe_q[PIPE_DLY-1];
  assign o_VBLANK_n    = vb_pipe_q[PIPE_DLY-1];

endmodule

// File: tb/tb_gx400_color_ram_out.sv
// Scoreboard bench for gx400_color_ram_out: a palette array model predicts every pixel and
// every CPU read; monitors compare whenever the DUT presents a pixel or raises an acknowledge.
module tb_gx400_color_ram_out;

  logic        clk = 1'b0;
  logic        i_RST_n, i_CEN6, i_HBLANK_n, i_VBLANK_n;
  logic [10:0] i_COLOR_RAM_ADDR, i_CPU_ADDR;
  logic        i_CPU_CS_n, i_CPU_RW, i_CPU_UDS_n, i_CPU_LDS_n;
  logic [15:0] i_CPU_DIN, o_CPU_DOUT;
  logic        o_CPU_DTACK_n, o_HBLANK_n, o_VBLANK_n;
  logic [4:0]  o_RED, o_GREEN, o_BLUE;

  always #5 clk = ~clk;

  gx400_color_ram_out dut (
    .i_CLK(clk), .i_RST_n(i_RST_n), .i_CEN6(i_CEN6), .i_COLOR_RAM_ADDR(i_COLOR_RAM_ADDR),
    .i_HBLANK_n(i_HBLANK_n), .i_VBLANK_n(i_VBLANK_n), .i_CPU_CS_n(i_CPU_CS_n),
    .i_CPU_RW(i_CPU_RW), .i_CPU_UDS_n(i_CPU_UDS_n), .i_CPU_LDS_n(i_CPU_LDS_n),
    .i_CPU_ADDR(i_CPU_ADDR), .i_CPU_DIN(i_CPU_DIN), .o_CPU_DOUT(o_CPU_DOUT),
    .o_CPU_DTACK_n(o_CPU_DTACK_n), .o_RED(o_RED), .o_GREEN(o_GREEN), .o_BLUE(o_BLUE),
    .o_HBLANK_n(o_HBLANK_n), .o_VBLANK_n(o_VBLANK_n)
  );

  typedef struct { logic [15:0] data; logic hb; logic vb; } px_t;
  typedef struct { bit is_rd; logic [15:0] data; } cpu_t;

  px_t         px_q[$];
  cpu_t        cpu_q[$];
  logic [15:0] pal [2048];
  int          checks = 0;
  int          failures = 0;
  bit          px_en = 1'b0;
  bit          px_force = 1'b0;
  logic [10:0] px_force_addr = '0;
  logic        px_force_hb = 1'b1;
  logic        dtack_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic uds_n, input logic lds_n);
    merge = {uds_n ? old[15:8] : d[15:8], lds_n ? old[7:0] : d[7:0]};
  endfunction

  function automatic logic [14:0] exp_rgb(input px_t e);
`ifdef GX400_PAL_BLANK_EN
    if (!(e.hb && e.vb)) return 15'h0000;
`endif
    return e.data[14:0];
  endfunction

  // Pixel clock enable every 4th clock; new pixel inputs right after each tick.
  initial begin
    int ph = 0;
    i_CEN6 = 1'b0;
    i_COLOR_RAM_ADDR = '0;
    i_HBLANK_n = 1'b1;
    i_VBLANK_n = 1'b1;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      i_CEN6 = (ph == 0);
      if (ph == 1) begin
        if (px_force) begin
          i_COLOR_RAM_ADDR = px_force_addr;
          i_HBLANK_n = px_force_hb;
          i_VBLANK_n = 1'b1;
        end else begin
          i_COLOR_RAM_ADDR = 11'($urandom_range(0, 127));
          i_HBLANK_n = ($urandom_range(0, 7) != 0);
          i_VBLANK_n = ($urandom_range(0, 7) != 0);
        end
      end
    end
  end

  // Expected pixel: palette contents as they stand before this edge's CPU write.
  always @(posedge clk) begin
    if (!i_RST_n) px_q.delete();
    else if (i_CEN6 && px_en)
      px_q.push_back('{data: pal[i_COLOR_RAM_ADDR], hb: i_HBLANK_n, vb: i_VBLANK_n});
  end

  // Pixel monitor: the output shows the entry issued one tick before the newest one.
  always @(posedge clk) begin
    if (i_CEN6 && i_RST_n) begin
      #1;
      if (px_q.size() >= 2) begin
        px_t e;
        e = px_q.pop_front();
        check("pixel", {o_BLUE, o_GREEN, o_RED, o_HBLANK_n, o_VBLANK_n},
              {exp_rgb(e), e.hb, e.vb});
      end
    end
  end

  // CPU monitor: on every acknowledge pop the oldest access; reads compare the data bus.
  always @(posedge clk) begin
    #2;
    if (dtack_prev && !o_CPU_DTACK_n && i_RST_n) begin
      if (cpu_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cpu_ack got=ack exp=no_pending_access");
      end else begin
        cpu_t e;
        e = cpu_q.pop_front();
        if (e.is_rd) check("cpu_read", o_CPU_DOUT, e.data);
      end
    end
    dtack_prev = o_CPU_DTACK_n;
  end

  task automatic wait_tick();
    do @(posedge clk); while (!i_CEN6);
    #1;
  endtask

  task automatic cpu_access(input bit rw, input logic uds_n, input logic lds_n,
                            input logic [10:0] a, input logic [15:0] d, input int hold,
                            input logic [15:0] d2, output logic [15:0] rdata);
    int lat, bad;
    @(negedge clk);
    i_CPU_CS_n = 1'b0; i_CPU_RW = rw; i_CPU_UDS_n = uds_n; i_CPU_LDS_n = lds_n;
    i_CPU_ADDR = a; i_CPU_DIN = d;
    @(posedge clk); #1;
    if (rw) cpu_q.push_back('{is_rd: 1'b1, data: pal[a]});
    else begin
      pal[a] = merge(pal[a], d, uds_n, lds_n);
      cpu_q.push_back('{is_rd: 1'b0, data: 16'h0000});
    end
    lat = 1;
    while (o_CPU_DTACK_n && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check(rw ? "rd_latency" : "wr_latency", lat, rw ? 2 : 1);
    rdata = o_CPU_DOUT;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) i_CPU_DIN = d2;
      if (i == 1) begin i_CPU_UDS_n = ~uds_n; i_CPU_LDS_n = 1'b0; end
      @(posedge clk); #1;
      if (o_CPU_DTACK_n) bad++;
    end
    if (hold > 0) check("dtack_hold", bad, 0);
    @(negedge clk);
    i_CPU_CS_n = 1'b1; i_CPU_UDS_n = 1'b1; i_CPU_LDS_n = 1'b1;
    @(posedge clk); #1;
    check("dtack_release", o_CPU_DTACK_n, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    i_RST_n = 1'b0;
    i_CPU_CS_n = 1'b0; i_CPU_RW = 1'b0; i_CPU_UDS_n = 1'b0; i_CPU_LDS_n = 1'b0;
    i_CPU_ADDR = 11'h07F; i_CPU_DIN = 16'h5A5A;
    for (int i = 0; i < 2048; i++) pal[i] = 16'h0000;

    // Reset with a write pending.
    repeat (4) @(posedge clk);
    #1;
    check("rst_rgb", {o_BLUE, o_GREEN, o_RED}, 15'h0000);
    check("rst_blank", {o_HBLANK_n, o_VBLANK_n}, 2'b00);
    check("rst_dtack", o_CPU_DTACK_n, 1'b1);
    check("rst_dout", o_CPU_DOUT, 16'h0000);
    @(negedge clk);
    i_RST_n = 1'b1;
    @(posedge clk); #1;
    pal[11'h07F] = 16'h5A5A;
    cpu_q.push_back('{is_rd: 1'b0, data: 16'h0000});
    check("rst_release_ack", o_CPU_DTACK_n, 1'b0);
    @(negedge clk);
    i_CPU_CS_n = 1'b1; i_CPU_UDS_n = 1'b1; i_CPU_LDS_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_dtack_up", o_CPU_DTACK_n, 1'b1);
    cpu_access(1'b1, 1'b0, 1'b0, 11'h07F, 16'h0, 0, 16'h0, rd);
    check("rst_write_data", rd, 16'h5A5A);

    // Load the palette region the pixel stream uses.
    for (int i = 0; i < 128; i++)
      cpu_access(1'b0, 1'b0, 1'b0, 11'(i), 16'($urandom), 0, 16'h0, rd);
    cpu_access(1'b0, 1'b0, 1'b0, 11'h050, 16'h03E0, 0, 16'h0, rd);
    cpu_access(1'b0, 1'b0, 1'b0, 11'h010, 16'h0000, 0, 16'h0, rd);
    cpu_access(1'b0, 1'b0, 1'b0, 11'h005, 16'h7FFF, 0, 16'h0, rd);
    px_en = 1'b1;

    // Word write then pixel read.
    cpu_access(1'b0, 1'b0, 1'b0, 11'h123, 16'h7C1F, 0, 16'h0, rd);
    px_force_addr = 11'h123; px_force_hb = 1'b1; px_force = 1'b1;
    repeat (4) wait_tick();
    check("word_pixel", {o_BLUE, o_GREEN, o_RED}, {5'd31, 5'd0, 5'd31});

    // Byte writes.
    cpu_access(1'b0, 1'b1, 1'b0, 11'h010, 16'hABCD, 0, 16'h0, rd);
    cpu_access(1'b0, 1'b0, 1'b1, 11'h010, 16'h1234, 0, 16'h0, rd);
    cpu_access(1'b1, 1'b0, 1'b0, 11'h010, 16'h0, 0, 16'h0, rd);
    check("byte_merge", rd, 16'h12CD);
    cpu_access(1'b1, 1'b0, 1'b1, 11'h010, 16'h0, 0, 16'h0, rd);
    check("uds_read_full", rd, 16'h12CD);

    // Collision: CPU write lands on the same edge that samples the pixel address.
    px_force_addr = 11'h050;
    repeat (3) wait_tick();
    fork
      begin
        repeat (3) @(negedge clk);
        cpu_access(1'b0, 1'b0, 1'b0, 11'h050, 16'h001F, 0, 16'h0, rd);
      end
      begin
        wait_tick();
        wait_tick();
        check("collision_old", {o_BLUE, o_GREEN, o_RED}, 15'h03E0);
        wait_tick();
        check("collision_new", {o_BLUE, o_GREEN, o_RED}, 15'h001F);
      end
    join

    // Blanking.
    px_force_addr = 11'h005; px_force_hb = 1'b0;
    repeat (4) wait_tick();
    check("blank_hb_out", o_HBLANK_n, 1'b0);
`ifdef GX400_PAL_BLANK_EN
    check("blank_rgb", {o_BLUE, o_GREEN, o_RED}, 15'h0000);
`else
    check("blank_rgb", {o_BLUE, o_GREEN, o_RED}, 15'h7FFF);
`endif
    px_force_hb = 1'b1;

    // Long CS with data and strobes changing mid-cycle.
    cpu_access(1'b0, 1'b0, 1'b1, 11'h020, 16'h1111, 20, 16'h2222, rd);
    cpu_access(1'b1, 1'b0, 1'b0, 11'h020, 16'h0, 0, 16'h0, rd);
    check("long_cs_data", rd, merge(pal[11'h020], 16'h1111, 1'b0, 1'b1));

    // CS low with both strobes high is not a cycle.
    begin
      int acks = 0;
      @(negedge clk);
      i_CPU_CS_n = 1'b0; i_CPU_RW = 1'b0; i_CPU_ADDR = 11'h021; i_CPU_DIN = 16'hDEAD;
      repeat (5) begin
        @(posedge clk); #1;
        if (!o_CPU_DTACK_n) acks++;
      end
      check("no_strobe_ack", acks, 0);
      @(negedge clk);
      i_CPU_CS_n = 1'b1;
      cpu_access(1'b1, 1'b1, 1'b0, 11'h021, 16'h0, 0, 16'h0, rd);
      check("no_strobe_data", rd, pal[11'h021]);
    end

    // Randomised traffic against the model.
    px_force = 1'b0;
    for (int n = 0; n < 80; n++) begin
      int op;
      logic [10:0] a;
      op = $urandom_range(0, 2);
      a = 11'($urandom_range(0, 127));
      case (op)
        0: cpu_access(1'b0, 1'b0, 1'b0, a, 16'($urandom), 0, 16'h0, rd);
        1: begin
          logic u;
          u = 1'($urandom);
          cpu_access(1'b0, u, ~u, a, 16'($urandom), $urandom_range(0, 3), 16'($urandom), rd);
        end
        default: begin
          int s;
          s = $urandom_range(0, 2);
          cpu_access(1'b1, s == 2, s == 1, a, 16'h0, 0, 16'h0, rd);
        end
      endcase
    end
    repeat (6) wait_tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
